// File: rtl/mult_column_arbiter_pkg.sv
// Shared BCH constants and GF(2^13) helpers (field poly x^13+x^4+x^3+x+1).
package mult_column_arbiter_pkg;

  localparam int GF_W      = 13;
  localparam int COL_DEPTH = 16;
  localparam int PROD_W    = 208;
  localparam int COL_STEP  = 4;

  localparam logic [GF_W-1:0] GF_POLY = 13'h001B;

  // Multiply by alpha: shift left, fold x^13 back in through the field polynomial.
  function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] v);
    return {v[GF_W-2:0], 1'b0} ^ (v[GF_W-1] ? GF_POLY : '0);
  endfunction

  function automatic logic [GF_W-1:0] gf_mul_alpha_pow(input logic [GF_W-1:0] v, input int n);
    logic [GF_W-1:0] acc;
    acc = v;
    for (int i = 0; i < n; i++) begin
      acc = gf_xtime(acc);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mult_column_arbiter_column.sv
// Column of 16 constant GF multipliers: prod[k] = b * alpha^(4*(k+1)).
// Purely combinational, no backpressure.
module multiplier_column4_p16
  import mult_column_arbiter_pkg::*;
(
  input  logic [GF_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  // Each column is an independent constant linear map, so no carry chain between them.
  for (genvar k = 0; k < COL_DEPTH; k++) begin : g_col
    assign prod[k*GF_W +: GF_W] = gf_mul_alpha_pow(b, COL_STEP * (k + 1));
  end

endmodule

// File: rtl/mult_column_arbiter.sv
// Two-requester round-robin front end sharing one column multiplier; 1-cycle latency.
// Readies drop while the result register is held (out_valid & !out_ready).
module mult_column_arbiter
  import mult_column_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [GF_W-1:0]   req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [GF_W-1:0]   req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic [TAG_W-1:0]  out_tag,
  output logic [PROD_W-1:0] out_prod,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  input  logic              cnt_clr
);

  logic              out_valid_q, out_valid_d;
  logic              out_src_q, out_src_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [PROD_W-1:0] out_prod_q, out_prod_d;
  logic [15:0]       gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0]       gnt_cnt1_q, gnt_cnt1_d;
  logic              last_grant_q, last_grant_d;

  logic              slot_free;
  logic              grant_sel;
  logic              accept;
  logic              acc0, acc1;
  logic [GF_W-1:0]   b_mux;
  logic [PROD_W-1:0] col_prod;

  // On conflict pick the requester not served last; otherwise whoever is valid.
  assign slot_free = !out_valid_q || out_ready;
  assign grant_sel = (req0_valid && req1_valid) ? !last_grant_q : (req1_valid && !req0_valid);
  assign accept    = slot_free && (req0_valid || req1_valid);
  assign acc0      = accept && !grant_sel;
  assign acc1      = accept && grant_sel;
  assign b_mux     = grant_sel ? req1_b : req0_b;

  multiplier_column4_p16 u_column (
    .b    (b_mux),
    .prod (col_prod)
  );

  always_comb begin
    out_valid_d  = out_valid_q && !out_ready;
    out_src_d    = out_src_q;
    out_tag_d    = out_tag_q;
    out_prod_d   = out_prod_q;
    last_grant_d = last_grant_q;
    gnt_cnt0_d   = gnt_cnt0_q;
    gnt_cnt1_d   = gnt_cnt1_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_src_d    = grant_sel;
      out_tag_d    = grant_sel ? req1_tag : req0_tag;
      out_prod_d   = col_prod;
      last_grant_d = grant_sel;
    end
    if (cnt_clr) begin
      gnt_cnt0_d = '0;
      gnt_cnt1_d = '0;
    end else begin
      if (acc0 && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
      if (acc1 && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_src_q    <= 1'b0;
      out_tag_q    <= '0;
      out_prod_q   <= '0;
      gnt_cnt0_q   <= '0;
      gnt_cnt1_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      out_tag_q    <= out_tag_d;
      out_prod_q   <= out_prod_d;
      gnt_cnt0_q   <= gnt_cnt0_d;
      gnt_cnt1_q   <= gnt_cnt1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign out_valid  = out_valid_q;
  assign out_src    = out_src_q;
  assign out_tag    = out_tag_q;
  assign out_prod   = out_prod_q;
  assign gnt_cnt0   = gnt_cnt0_q;
  assign gnt_cnt1   = gnt_cnt1_q;

endmodule

// File: tb/tb_mult_column_arbiter.sv
// Scoreboard bench for mult_column_arbiter against a GF(2^13) reference model.
module tb_mult_column_arbiter;
  import mult_column_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [12:0]   req0_b = '0, req1_b = '0;
  logic [3:0]    req0_tag = '0, req1_tag = '0;
  logic          req0_ready, req1_ready;
  logic          out_valid, out_src;
  logic          out_ready = 1'b0;
  logic [3:0]    out_tag;
  logic [207:0]  out_prod;
  logic [15:0]   gnt_cnt0, gnt_cnt1;
  logic          cnt_clr = 1'b0;

  always #5 clk = ~clk;

  mult_column_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_b(req0_b), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_b(req1_b), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_tag(out_tag),
    .out_prod(out_prod), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .cnt_clr(cnt_clr)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         src;
    logic [3:0]   tag;
    logic [207:0] prod;
  } exp_t;
  exp_t sbq[$];

  // Reference state: who was served last, whether a result is pending, grant totals.
  logic        m_last = 1'b1;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0;
  logic        mon_en = 1'b0;
  logic [12:0] apow [1:16];

  task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Schoolbook carry-less multiply with reduction, independent of any alpha-power trick.
  function automatic logic [12:0] gf_mul(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 13; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[11:0], 1'b0} ^ (x[12] ? 13'h001B : 13'h0000);
    end
    return r;
  endfunction

  function automatic logic [207:0] golden(input logic [12:0] b);
    logic [207:0] p;
    p = '0;
    for (int k = 1; k <= 16; k++) p[(k-1)*13 +: 13] = gf_mul(b, apow[k]);
    return p;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic cycle(input logic v0, input logic [12:0] b0, input logic [3:0] t0,
                       input logic v1, input logic [12:0] b1, input logic [3:0] t1,
                       input logic ordy, input logic clr);
    logic slot, g0, g1;
    exp_t e;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_b = b0; req0_tag = t0;
    req1_valid = v1; req1_b = b1; req1_tag = t1;
    out_ready = ordy; cnt_clr = clr;
    @(negedge clk);
    slot = !m_valid || ordy;
    g0 = slot && v0 && (!v1 || m_last);
    g1 = slot && v1 && (!v0 || !m_last);
    chk("req0_ready", 208'(req0_ready), 208'(g0));
    chk("req1_ready", 208'(req1_ready), 208'(g1));
    chk("gnt_cnt0", 208'(gnt_cnt0), 208'(m_cnt0));
    chk("gnt_cnt1", 208'(gnt_cnt1), 208'(m_cnt1));
    if (g0 || g1) begin
      e.src = g1;
      e.tag = g1 ? t1 : t0;
      e.prod = golden(g1 ? b1 : b0);
      sbq.push_back(e);
      m_last = g1;
    end
    if (clr) begin
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      if (g0) m_cnt0 = sat_inc(m_cnt0);
      if (g1) m_cnt1 = sat_inc(m_cnt1);
    end
    m_valid = (g0 || g1) || (m_valid && !ordy);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  // Reset lands mid-cycle so the asynchronous clear is observable before any edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 208'(out_valid), 208'(0));
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    sbq.delete();
    m_valid = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
    #12;
    chk("rst_out_src", 208'(out_src), 208'(0));
    chk("rst_out_tag", 208'(out_tag), 208'(0));
    chk("rst_out_prod", out_prod, 208'(0));
    chk("rst_gnt_cnt0", 208'(gnt_cnt0), 208'(0));
    chk("rst_gnt_cnt1", 208'(gnt_cnt1), 208'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: pops on every handshake and checks that held results do not move.
  initial begin
    logic         held_prev;
    logic         p_src;
    logic [3:0]   p_tag;
    logic [207:0] p_prod;
    exp_t         e;
    held_prev = 1'b0;
    p_src = 1'b0; p_tag = '0; p_prod = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        held_prev = 1'b0;
      end else begin
        if (held_prev) begin
          chk("hold_valid", 208'(out_valid), 208'(1));
          chk("hold_src", 208'(out_src), 208'(p_src));
          chk("hold_tag", 208'(out_tag), 208'(p_tag));
          chk("hold_prod", out_prod, p_prod);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", 208'(1), 208'(0));
          end else begin
            e = sbq.pop_front();
            chk("out_src", 208'(out_src), 208'(e.src));
            chk("out_tag", 208'(out_tag), 208'(e.tag));
            chk("out_prod", out_prod, e.prod);
          end
        end
        held_prev = out_valid && !out_ready;
        p_src = out_src; p_tag = out_tag; p_prod = out_prod;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] a;
    logic        exp_order [4];
    a = 13'h0001;
    for (int k = 1; k <= 16; k++) begin
      for (int j = 0; j < 4; j++) a = gf_mul(a, 13'h0002);
      apow[k] = a;
    end
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    do_reset();

    // Single lone request, then hold it to inspect the registered result.
    cycle(1'b1, 13'h0001, 4'd3, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b0);
    chk("first_valid", 208'(out_valid), 208'(1));
    chk("first_src", 208'(out_src), 208'(0));
    chk("first_tag", 208'(out_tag), 208'(3));
    chk("first_p1", 208'(out_prod[12:0]), 208'(13'h0010));

    // Reset while the result is pending; the first conflict afterwards goes to requester 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 13'(i + 5), 4'(i), 1'b1, 13'(i + 100), 4'(i + 8), 1'b1, 1'b0);
      chk("rr_order", 208'(req1_ready), 208'(exp_order[i]));
    end
    idle(1'b1);
    chk("rr_cnt0", 208'(gnt_cnt0), 208'(16'd2));
    chk("rr_cnt1", 208'(gnt_cnt1), 208'(16'd2));

    // Backpressure: one result held for five cycles while both requesters wait.
    cycle(1'b0, '0, '0, 1'b1, 13'(32'($urandom_range(8191))), 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 13'(32'($urandom_range(8191))), 4'd1, 1'b1, 13'(32'($urandom_range(8191))), 4'd2, 1'b0, 1'b0);
    idle(1'b1);

    cycle(1'b1, 13'h0000, 4'd7, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b0);
    chk("zero_prod", out_prod, 208'(0));

    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(1)), 13'(32'($urandom_range(8191))), 4'(32'($urandom_range(15))),
            1'($urandom_range(1)), 13'(32'($urandom_range(8191))), 4'(32'($urandom_range(15))),
            1'($urandom_range(3) != 0), 1'($urandom_range(40) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Saturation: walk counter 0 up to FFFE, then past the ceiling.
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      if (m_cnt0 == 16'hFFFE) break;
      cycle(1'b1, 13'(i), 4'(i), 1'b0, '0, '0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 13'h0abc, 4'd5, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b1);
    chk("sat_cnt0", 208'(gnt_cnt0), 208'(16'hFFFF));
    cycle(1'b1, 13'h0123, 4'd6, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);
    chk("clr_cnt0", 208'(gnt_cnt0), 208'(16'h0000));
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("sb_empty", 208'(sbq.size()), 208'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_column_arbiter.md
MULT_COLUMN_ARBITER -- requirements
Module: mult_column_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, giving the width of the request tag carried through with each operand.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, operand offered by requester 0 (syndrome unit) or 1 (Chien unit).
REQ-005 SHALL have ports req0_b / req1_b, input, 13 each, GF(2^13) operand.
REQ-006 SHALL have ports req0_tag / req1_tag, input, TAG_W each, opaque tag returned with the result.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each, operand accepted this cycle when valid and ready are both high.
REQ-008 SHALL have port out_valid, output, 1, result register holds a result.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes the result when out_valid and out_ready are both high.
REQ-010 SHALL have port out_src, output, 1, index of the requester that owns the result.
REQ-011 SHALL have port out_tag, output, TAG_W, tag of the accepted request.
REQ-012 SHALL have port out_prod, output, 208, the 16 column products, P1 in [12:0] up to P16 in [207:195].
REQ-013 SHALL have ports gnt_cnt0 / gnt_cnt1, output, 16 each, saturating per-requester grant counts.
REQ-014 SHALL have port cnt_clr, input, 1, synchronous clear of both grant counters.

Function
REQ-015 SHALL have "slot free" = !out_valid | out_ready.
REQ-016 SHALL accept at most one request per cycle, and only when the slot is free.
REQ-017 SHALL grant a lone valid requester immediately.
REQ-018 SHALL resolve a conflict (both valid) round-robin: grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first conflict.
REQ-019 SHALL drive reqN_ready combinationally: high only for the granted requester in a slot-free cycle, otherwise low.
REQ-020 SHALL, on accept, load out_prod with the column products of the granted operand, load out_src and out_tag, and set out_valid on the next edge (latency 1 cycle).
REQ-021 SHALL clear out_valid on consume when no new accept occurs; consume plus accept in the same cycle SHALL give back-to-back results with no bubble.
REQ-022 SHALL hold out_valid, out_src, out_tag and out_prod stable while out_valid is high and out_ready is low; both readies SHALL be low then.
REQ-023 SHALL leave last_grant unchanged in cycles with no accept.
REQ-024 SHALL increment gnt_cntN on each accept from requester N, saturating at 16'hFFFF.
REQ-025 SHALL give cnt_clr priority over an increment in the same cycle (counter becomes 0).
REQ-026 SHALL compute products purely combinationally from the granted operand; a sustained throughput of one result per cycle is required.

Reset
REQ-027 SHALL, while rst_n is low, force out_valid=0, out_src=0, out_tag=0, out_prod=0, gnt_cnt0=gnt_cnt1=0 and last_grant=1, regardless of clk.
REQ-028 SHALL discard any in-flight result when reset is asserted mid-operation; nothing is replayed after release.

Structure
REQ-029 SHALL place the GF width (13), the column depth (16) and the product bus width (208) as constants in the shared BCH package.
REQ-030 SHALL instantiate exactly one sub-module, multiplier_column4_p16, fed by the grant-muxed operand.

Verification
REQ-031 SHALL check: reset, then req0 only with b=13'h0001, tag=3 -> one cycle later out_valid=1, out_src=0, out_tag=3, out_prod[12:0]=13'h0010.
REQ-032 SHALL check: both requesters valid for 4 cycles, out_ready=1 -> grants in the order 0,1,0,1; gnt_cnt0=2, gnt_cnt1=2.
REQ-033 SHALL check: out_ready=0 for 5 cycles with a result held -> out_* stable, both readies 0, counters unchanged.
REQ-034 SHALL check: b=13'h0000 -> out_prod=0; random operands -> out_prod equals the golden GF(2^13) model for all 16 products.
REQ-035 SHALL check: counter preloaded to 16'hFFFE with 3 further grants -> 16'hFFFF; cnt_clr together with a grant -> 0.
REQ-036 SHALL check: rst_n asserted while out_valid=1 -> out_valid=0 immediately (asynchronous); after release, the first conflict is granted to requester 0.
